// File: rtl/instr_seq.sv
// instr_seq -- program sequencer for one TIS-100 execution node.
//
// Holds a runtime-loadable instruction memory and a program counter, and
// resolves jumps from op/acc/jmp_off. The fetched word is registered on out
// so decode/execute sees mem[pc] in the same cycle pc is presented.
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   clk_en            advance enable; low = node stalled, all state holds
//   op, acc, jmp_off  opcode of the word on out, signed acc, signed jump operand
//   prog_en/we/addr/data  program-load port; sequencer halted while prog_en=1
//   out, pc, valid    registered instruction, program counter, out-is-fetched flag
module instr_seq #(
    parameter  int INSTR_W = 21,
    parameter  int DEPTH   = 15,
    parameter  int DATA_W  = 11,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [3:0]         op,
    input  logic [DATA_W-1:0]  acc,
    input  logic [DATA_W-1:0]  jmp_off,
    input  logic               prog_en,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] out,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);
    // prog_len ranges 0..DEPTH, so it may need one more bit than an address.
    localparam int LEN_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JEZ = 4'h9;
    localparam logic [3:0] OP_JNZ = 4'hA;
    localparam logic [3:0] OP_JGZ = 4'hB;
    localparam logic [3:0] OP_JLZ = 4'hC;
    localparam logic [3:0] OP_JRO = 4'hD;

    typedef enum logic [1:0] {S_PRIME, S_RUN, S_PROG} state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
    logic [INSTR_W-1:0]   r_out, w_out_nxt;
    logic [LEN_W-1:0]     r_len, w_len_nxt;
    logic [INSTR_W-1:0]   r_mem [DEPTH];

    logic                     w_wr;
    logic [LEN_W-1:0]         w_wr_len;
    logic signed [DATA_W-1:0] w_acc_s;
    logic signed [DATA_W:0]   w_last, w_tgt_raw, w_rel_raw;
    logic [ADDR_W-1:0]        w_seq, w_tgt, w_rel, w_next_pc;

    // Clamp a signed candidate address into [0, hi].
    function automatic logic [ADDR_W-1:0] clamp_addr(input logic signed [DATA_W:0] v,
                                                     input logic signed [DATA_W:0] hi);
        if (v < 0)       return '0;
        else if (v > hi) return hi[ADDR_W-1:0];
        else             return v[ADDR_W-1:0];
    endfunction

    assign w_wr     = prog_en && prog_we && (int'(prog_addr) < DEPTH);
    assign w_wr_len = LEN_W'(prog_addr) + LEN_W'(1);

    // Jump resolution; all arithmetic is signed in DATA_W+1 bits so pc+offset
    // can never wrap before clamping.
    assign w_acc_s   = acc;
    assign w_last    = $signed((DATA_W+1)'(r_len)) - (DATA_W+1)'(1);
    assign w_tgt_raw = {jmp_off[DATA_W-1], jmp_off};
    assign w_rel_raw = $signed((DATA_W+1)'(r_pc)) + w_tgt_raw;
    assign w_seq     = (LEN_W'(r_pc) + LEN_W'(1) == r_len) ? '0 : r_pc + ADDR_W'(1);
    assign w_tgt     = clamp_addr(w_tgt_raw, w_last);
    assign w_rel     = clamp_addr(w_rel_raw, w_last);

    always_comb begin
        w_next_pc = w_seq;
        case (op)
            OP_JMP:  w_next_pc = w_tgt;
            OP_JEZ:  w_next_pc = (w_acc_s == 0) ? w_tgt : w_seq;
            OP_JNZ:  w_next_pc = (w_acc_s != 0) ? w_tgt : w_seq;
            OP_JGZ:  w_next_pc = (w_acc_s > 0)  ? w_tgt : w_seq;
            OP_JLZ:  w_next_pc = (w_acc_s < 0)  ? w_tgt : w_seq;
            OP_JRO:  w_next_pc = w_rel;
            default: w_next_pc = w_seq;
        endcase
    end

    // Next-state / datapath. prog_en wins over clk_en; leaving PROG is
    // unconditional so a stalled node still re-primes after a load.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_out_nxt   = r_out;
        w_len_nxt   = r_len;
        if (prog_en) begin
            w_state_nxt = S_PROG;
            w_out_nxt   = '0;
            w_len_nxt   = (r_state == S_PROG) ? r_len : '0;
            if (w_wr && (w_wr_len > w_len_nxt))
                w_len_nxt = w_wr_len;
        end else if (r_state == S_PROG) begin
            w_state_nxt = S_PRIME;
            w_pc_nxt    = '0;
            w_out_nxt   = '0;
        end else if (clk_en) begin
            case (r_state)
                S_PRIME: begin
                    w_pc_nxt = '0;
                    if (r_len != '0) begin
                        w_state_nxt = S_RUN;
                        w_out_nxt   = r_mem[0];
                    end else begin
                        w_out_nxt   = '0;
                    end
                end
                S_RUN: begin
                    w_pc_nxt  = w_next_pc;
                    w_out_nxt = r_mem[w_next_pc];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_PRIME;
            r_pc    <= '0;
            r_out   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_out   <= w_out_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Instruction storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[prog_addr] <= prog_data;
    end

    assign out   = r_out;
    assign pc    = r_pc;
    assign valid = (r_state == S_RUN) && (r_len != '0);
endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: a jump-resolution vector table plus
// hand-written sequences for load/wrap, stall, reset and short programs.
module tb_instr_seq;
    localparam int INSTR_W = 21;
    localparam int DEPTH   = 15;
    localparam int DATA_W  = 11;
    localparam int ADDR_W  = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               reset, clk_en, prog_en, prog_we;
    logic [3:0]         op;
    logic [DATA_W-1:0]  acc, jmp_off;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [INSTR_W-1:0] out;
    logic [ADDR_W-1:0]  pc;
    logic               valid;

    instr_seq dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .op(op), .acc(acc),
        .jmp_off(jmp_off), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .out(out), .pc(pc), .valid(valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [INSTR_W-1:0] exp_mem [DEPTH];

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] off;
        int                start;
        int                exp_pc;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [3:0] o, input int a, input int f,
                                input int s, input int e);
        vec_t v;
        v.op = o; v.acc = DATA_W'(a); v.off = DATA_W'(f); v.start = s; v.exp_pc = e;
        return v;
    endfunction

    // Word 0 of the long program is zero so out after a reset-reprime is
    // unambiguous whichever way the empty-program case is read.
    function automatic logic [INSTR_W-1:0] word(input int i);
        return (i == 0) ? '0 : INSTR_W'(32'h5000 + i * 17);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load words 0..n-1, release prog_en and prime (out=mem[0], pc=0).
    task automatic load_prog(input int n);
        clk_en  = 1'b0;
        prog_en = 1'b1;
        prog_we = 1'b1;
        for (int i = 0; i < n; i++) begin
            prog_addr  = ADDR_W'(i);
            prog_data  = word(i);
            exp_mem[i] = word(i);
            tick();
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        tick();
        clk_en = 1'b1;
        op = 4'h0;
        tick();
        chk("prime_out", 32'(out), 32'(exp_mem[0]));
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; prog_en = 1'b0; prog_we = 1'b0;
        op = 4'h0; acc = '0; jmp_off = '0; prog_addr = '0; prog_data = '0;

        vecs[0]  = mk(4'hD, 0, -7, 3, 0);      // JRO back, clamp low
        vecs[1]  = mk(4'hD, 0, 5, 8, 9);       // JRO fwd, clamp high
        vecs[2]  = mk(4'hD, 0, 2, 4, 6);       // JRO in range
        vecs[3]  = mk(4'h9, 0, 7, 2, 7);       // JEZ taken
        vecs[4]  = mk(4'h9, 1, 7, 2, 3);       // JEZ not taken
        vecs[5]  = mk(4'hB, -1024, 7, 2, 3);   // JGZ most negative
        vecs[6]  = mk(4'hC, -1, 7, 2, 7);      // JLZ taken
        vecs[7]  = mk(4'hA, 5, 7, 2, 7);       // JNZ taken
        vecs[8]  = mk(4'hA, 0, 7, 2, 3);       // JNZ not taken
        vecs[9]  = mk(4'h8, 0, 100, 1, 9);     // JMP clamp high
        vecs[10] = mk(4'h8, 0, -3, 5, 0);      // JMP clamp low
        vecs[11] = mk(4'h0, 0, 0, 9, 0);       // seq wrap at prog_len
        vecs[12] = mk(4'hD, 0, 1023, 2, 9);    // JRO max offset
        vecs[13] = mk(4'hB, 1023, 7, 0, 7);    // JGZ most positive
        vecs[14] = mk(4'hC, 0, 7, 6, 7);       // JLZ acc=0 -> seq

        #12;
        chk("rst_out", 32'(out), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_valid", 32'(valid), 0);
        @(negedge clk);
        reset = 1'b0;

        // Four-word program wraps at prog_len, not DEPTH.
        prog_en = 1'b1; prog_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prog_addr = ADDR_W'(i);
            prog_data = INSTR_W'(32'h0AAAA + i * 32'h1111);
            tick();
        end
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        chk("prime_valid", 32'(valid), 0);
        chk("prime_out0", 32'(out), 0);
        clk_en = 1'b1; op = 4'h0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("wrap4_out", 32'(out), 32'h0AAAA + (k % 4) * 32'h1111);
            chk("wrap4_pc", 32'(pc), k % 4);
        end
        chk("wrap4_valid", 32'(valid), 1);

        // Jump table on a ten-word program.
        load_prog(10);
        for (int i = 0; i < 15; i++) begin
            op = 4'h8; jmp_off = DATA_W'(vecs[i].start); acc = '0;
            tick();
            op = vecs[i].op; acc = vecs[i].acc; jmp_off = vecs[i].off;
            tick();
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(exp_mem[vecs[i].exp_pc]));
        end

        // Asynchronous reset while running at pc=5.
        op = 4'h8; jmp_off = DATA_W'(5);
        tick();
        chk("pre_rst_pc", 32'(pc), 5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", 32'(out), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_valid", 32'(valid), 0);
        @(negedge clk);
        reset = 1'b0; op = 4'h0;
        tick();
        chk("post_rst_out", 32'(out), 32'(exp_mem[0]));
        chk("post_rst_pc", 32'(pc), 0);

        // Stall holds pc/out; prog_en wins over a low clk_en.
        load_prog(10);
        op = 4'h8; jmp_off = DATA_W'(3);
        tick();
        chk("stall_pre_pc", 32'(pc), 3);
        clk_en = 1'b0; jmp_off = DATA_W'(7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", 32'(pc), 3);
            chk("stall_out", 32'(out), 32'(exp_mem[3]));
        end
        prog_en = 1'b1;
        tick();
        chk("prog_stall_out", 32'(out), 0);
        chk("prog_stall_valid", 32'(valid), 0);
        prog_en = 1'b0;
        tick();
        clk_en = 1'b1; op = 4'h0;
        tick();
        chk("empty_valid", 32'(valid), 0);
        chk("empty_out", 32'(out), 0);
        tick();
        chk("empty_valid2", 32'(valid), 0);
        chk("empty_pc", 32'(pc), 0);

        // Out-of-range write ignored; addr 2 alone sets prog_len=3.
        clk_en = 1'b0; prog_en = 1'b1; prog_we = 1'b1;
        prog_addr = ADDR_W'(DEPTH); prog_data = INSTR_W'(32'h1EEEE);
        tick();
        prog_addr = ADDR_W'(2); prog_data = INSTR_W'(32'h13333);
        exp_mem[2] = INSTR_W'(32'h13333);
        tick();
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        clk_en = 1'b1; op = 4'h0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("len3_pc", 32'(pc), k % 3);
            chk("len3_out", 32'(out), 32'(exp_mem[k % 3]));
        end
        chk("len3_valid", 32'(valid), 1);

        // Single-slot program: every next_pc is 0, whatever the op.
        clk_en = 1'b0; prog_en = 1'b1; prog_we = 1'b1;
        prog_addr = '0; prog_data = INSTR_W'(32'h17777);
        tick();
        prog_we = 1'b0; prog_en = 1'b0;
        tick();
        clk_en = 1'b1;
        tick();
        op = 4'hD; jmp_off = DATA_W'(3);
        tick();
        chk("len1_jro_pc", 32'(pc), 0);
        op = 4'h0;
        tick();
        chk("len1_seq_pc", 32'(pc), 0);
        chk("len1_out", 32'(out), 32'h17777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
